// File: rtl/serial_frame_rx.sv
// Framed asynchronous serial receiver: start bit, p_WIDTH data bits LSB first, one stop bit.
// Received words land in a one-entry holding register with a valid/ack handshake.
module serial_frame_rx #(
  parameter int unsigned p_WIDTH  = 8,
  parameter int unsigned p_PERIOD = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_rx,
  input  logic               i_rx_enable,
  output logic [p_WIDTH-1:0] ov_data,
  output logic               o_data_valid,
  input  logic               i_data_ack,
  output logic               o_frame_error,
  output logic               o_overrun,
  input  logic               i_err_clear,
  output logic               o_busy
);

  localparam int unsigned CntW = $clog2(p_PERIOD);
  localparam int unsigned IdxW = $clog2(p_WIDTH);
  localparam logic [CntW-1:0] CntHalf = CntW'(p_PERIOD / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(p_PERIOD - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(p_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e             state_q;
  logic               rx_m_q, rx_s_q;
  logic [CntW-1:0]    cnt_q;
  logic [IdxW-1:0]    idx_q;
  logic [p_WIDTH-1:0] shreg_q;
  logic [p_WIDTH-1:0] data_q;
  logic               valid_q, ferr_q, ovr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_m_q <= i_rx;
      rx_s_q <= rx_m_q;
      cnt_q  <= cnt_q + 1'b1;

      if (i_data_ack && valid_q) valid_q <= 1'b0;
      // Clear first so a set event on the same edge overrides it.
      if (i_err_clear) begin
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end

      if (!i_rx_enable) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q <= '0;
            if (!rx_s_q) state_q <= StStart;
          end
          StStart: begin
            if (cnt_q == CntHalf) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= rx_s_q ? StIdle : StData;
            end
          end
          StData: begin
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              shreg_q <= {rx_s_q, shreg_q[p_WIDTH-1:1]};
              idx_q   <= idx_q + IdxW'(1);
              if (idx_q == IdxLast) state_q <= StStop;
            end
          end
          StStop: begin
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
              if (rx_s_q) begin
                state_q <= StIdle;
                // An ack on this same cycle frees the register for the new word.
                if (!valid_q || i_data_ack) begin
                  data_q  <= shreg_q;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end else begin
                ferr_q  <= 1'b1;
                state_q <= StBreak;
              end
            end
          end
          StBreak: begin
            cnt_q <= '0;
            if (rx_s_q) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ov_data       = data_q;
  assign o_data_valid  = valid_q;
  assign o_frame_error = ferr_q;
  assign o_overrun     = ovr_q;
  assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized self-checking bench for serial_frame_rx against a frame-level outcome model.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n, rx, en, ack, clr;
  logic [7:0] data;
  logic       valid, fe, ovr, busy;

  // Frame-level model: what the holding register and flags should show.
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;
  int         n_cmp = 0;
  int         n_bad = 0;

  serial_frame_rx #(.p_WIDTH(8), .p_PERIOD(16)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rx         (rx),
    .i_rx_enable  (en),
    .ov_data      (data),
    .o_data_valid (valid),
    .i_data_ack   (ack),
    .o_frame_error(fe),
    .o_overrun    (ovr),
    .i_err_clear  (clr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"}, {24'd0, data}, {24'd0, m_data});
    check({tag, "_valid"}, {31'd0, valid}, {31'd0, m_valid});
    check({tag, "_ferr"}, {31'd0, fe}, {31'd0, m_ferr});
    check({tag, "_ovr"}, {31'd0, ovr}, {31'd0, m_ovr});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Drives one full frame, 16 clocks per bit. ack_stop pulses ack on the cycle the
  // receiver samples the stop bit (11th clock of the stop bit after the 2-flop sync).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_stop,
                            input int low_tail);
    logic pre_valid;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = stop;
    tick(10);
    pre_valid = m_valid;
    if (stop && !pre_valid) check("lat_pre", {31'd0, valid}, 32'd0);
    ack = ack_stop;
    tick(1);
    ack = 1'b0;
    if (stop && !pre_valid) check("lat_post", {31'd0, valid}, 32'd1);
    tick(5);
    if (!stop && low_tail > 0) begin
      tick(low_tail);
      check("break_busy", {31'd0, busy}, 32'd1);
      check("break_valid", {31'd0, valid}, {31'd0, m_valid && !ack_stop});
    end
    rx = 1'b1;
    tick(4);
    if (stop) begin
      if (!m_valid || ack_stop) begin
        m_data  = d;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
      if (ack_stop) m_valid = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic err_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    rx = 1'b1; en = 1'b1; ack = 1'b0; clr = 1'b0; rst_n = 1'b1;
    m_data = 8'd0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;

    // Reset asserted between edges must clear outputs without a clock.
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("reset_busy", {31'd0, busy}, 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0, 0);
    check_all("a5");
    ack_pulse();
    check_all("a5_ack");
    ack_pulse();
    check_all("ack_idle");

    // Short low glitch is rejected at the start-bit midpoint.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(16);
    check_all("glitch");

    send_frame(8'h3C, 1'b0, 1'b0, 100);
    check_all("break");
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    check_all("after_break");
    err_clear();
    check_all("clear");
    ack_pulse();

    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    check_all("overrun");
    err_clear();
    ack_pulse();
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    check_all("ack_at_stop");
    ack_pulse();

    // Abort mid-data via enable, then a clean frame.
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      tick(16);
    end
    en = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3);
    en = 1'b1;
    tick(4);
    check_all("abort");
    send_frame(8'h77, 1'b1, 1'b0, 0);
    check_all("x77");

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       stop, ack_stop;
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 7) != 0);
      ack_stop = ($urandom_range(0, 3) == 0);
      send_frame(d, stop, ack_stop, 0);
      check_all("rand");
      case ($urandom_range(0, 3))
        0: ack_pulse();
        1: err_clear();
        default: ;
      endcase
      check_all("rand_post");
    end

    // Async reset in the middle of a frame.
    send_frame(8'h96, 1'b1, 1'b0, 0);
    rx = 1'b0;
    tick(40);
    #2 rst_n = 1'b0;
    m_data = 8'd0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    #1 check_all("mid_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
